ifetch_unit: RTL and testbench

Instruction fetch front-end that sits directly upstream of the `datapath` inside `mips`. It owns the program counter and issues single-outstanding requests to instruction memory. Returned words go into a small prefetch buffer, which feeds decode through a valid/ready handshake. Branch/jump redirects from the datapath flush the buffer and squash any in-flight fetch.

---
 rtl/ifetch_unit.sv | 172 +++++++++++++++++
 tb/tb_ifetch_unit.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Instruction fetch front-end: PC, single-outstanding imem requests, prefetch FIFO to decode.
// Optional misaligned-redirect trap is enabled by defining IFETCH_ADEL_CHECK_EN.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic        id_adel
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALT} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pc_q, pc_d;
    logic [31:0]        addr_q, addr_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic               adel_pend_q, adel_pend_d;
    logic [31:0]        buf_pc_q    [BUF_DEPTH];
    logic [31:0]        buf_pc_d    [BUF_DEPTH];
    logic [31:0]        buf_instr_q [BUF_DEPTH];
    logic [31:0]        buf_instr_d [BUF_DEPTH];

    logic               push;
    logic               pop;
    logic [31:0]        push_instr;
    logic [31:0]        tgt_pc_c;
    logic               tgt_adel_c;

`ifdef IFETCH_ADEL_CHECK_EN
    logic               buf_adel_q [BUF_DEPTH];
    logic               buf_adel_d [BUF_DEPTH];
    logic               push_adel;

    assign tgt_pc_c   = redirect_pc;
    assign tgt_adel_c = |redirect_pc[1:0];
    assign id_adel    = buf_adel_q[rd_ptr_q];
`else
    assign tgt_pc_c   = redirect_pc & 32'hFFFF_FFFC;
    assign tgt_adel_c = 1'b0;
    assign id_adel    = 1'b0;
`endif

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign id_valid  = (cnt_q != '0);
    assign id_instr  = buf_instr_q[rd_ptr_q];
    assign id_pc     = buf_pc_q[rd_ptr_q];

    // Next-state, FIFO bookkeeping and redirect handling
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        cnt_d       = cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        adel_pend_d = adel_pend_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
`ifdef IFETCH_ADEL_CHECK_EN
        buf_adel_d  = buf_adel_q;
        push_adel   = 1'b0;
`endif
        push        = 1'b0;
        push_instr  = imem_rdata;
        pop         = id_valid & id_ready;

        case (state_q)
            IDLE: begin
                if (pop || (cnt_q < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    push = 1'b1;
                    pc_d = pc_q + 32'd4;
                    if ((cnt_q + CNT_W'(1) - CNT_W'(pop)) >= DEPTH_C) state_d = IDLE;
                end
            end
            DISCARD: begin
                if (imem_ack) state_d = adel_pend_q ? HALT : REQ;
            end
            HALT: begin
                if (adel_pend_q) begin
                    push        = 1'b1;
                    push_instr  = 32'h0;
                    adel_pend_d = 1'b0;
`ifdef IFETCH_ADEL_CHECK_EN
                    push_adel   = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            buf_pc_d[wr_ptr_q]    = pc_q;
            buf_instr_d[wr_ptr_q] = push_instr;
`ifdef IFETCH_ADEL_CHECK_EN
            buf_adel_d[wr_ptr_q]  = push_adel;
`endif
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

        // Redirect flushes everything; an unacked request must still drain its ack
        if (redirect_valid) begin
            cnt_d       = '0;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            pc_d        = tgt_pc_c;
            adel_pend_d = tgt_adel_c;
            if (((state_q == REQ) || (state_q == DISCARD)) && !imem_ack) state_d = DISCARD;
            else state_d = tgt_adel_c ? HALT : REQ;
        end

        req_d  = (state_d == REQ) || (state_d == DISCARD);
        addr_d = (state_d == DISCARD) ? addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            adel_pend_q <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_pc_q[i]    <= '0;
                buf_instr_q[i] <= '0;
`ifdef IFETCH_ADEL_CHECK_EN
                buf_adel_q[i]  <= 1'b0;
`endif
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            addr_q      <= addr_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            adel_pend_q <= adel_pend_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
`ifdef IFETCH_ADEL_CHECK_EN
            buf_adel_q  <= buf_adel_d;
`endif
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: transaction-level model (fetch stream, occupancy, dead requests) plus directed literals.
module tb_ifetch_unit;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int DEPTH = 2;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_adel;

    logic        mem_auto, mem_rand, mem_ack, man_ack;
    logic [31:0] mem_rdata, man_rdata;
    logic        chk_en;
    int          n_chk, n_fail;

    assign imem_ack   = mem_auto ? mem_ack   : man_ack;
    assign imem_rdata = mem_auto ? mem_rdata : man_rdata;

    ifetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_instr(id_instr), .id_pc(id_pc), .id_adel(id_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5C3_0F69;
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] a);
`ifdef IFETCH_ADEL_CHECK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: got timeout expected event at %0t", name, $time);
    endtask

    task automatic wait_valid(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (id_valid) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("wait_id_valid");
    endtask

    task automatic wait_req(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (imem_req) begin ok = 1'b1; break; end
        end
        if (!ok) timeout("wait_imem_req");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Instruction memory: answers after 0..3 cycles, data is a fixed function of address
    initial begin
        int wait_cnt, cur_delay;
        bit in_prog;
        mem_ack = 1'b0; mem_rdata = '0; in_prog = 1'b0; wait_cnt = 0; cur_delay = 0;
        forever begin
            @(posedge clk);
            #2;
            mem_ack = 1'b0;
            if (mem_auto && imem_req && !reset) begin
                if (!in_prog) begin
                    in_prog = 1'b1;
                    wait_cnt = 0;
                    cur_delay = mem_rand ? int'($urandom_range(0, 3)) : 0;
                end
                if (wait_cnt == cur_delay) begin
                    mem_ack = 1'b1;
                    mem_rdata = memf(imem_addr);
                    in_prog = 1'b0;
                end else begin
                    wait_cnt++;
                    mem_rdata = $urandom;
                end
            end else begin
                in_prog = 1'b0;
            end
        end
    end

    // Reference model and per-cycle compare
    initial begin
        logic [31:0] m_fetch, m_next, prev_addr;
        int m_cnt;
        bit m_dead, prev_hold, ack_v, pop, accepted;
        m_fetch = RST_PC; m_next = RST_PC; m_cnt = 0; m_dead = 0; prev_hold = 0; prev_addr = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_fetch = RST_PC; m_next = RST_PC; m_cnt = 0; m_dead = 0; prev_hold = 0;
            end else begin
                ack_v    = imem_req && imem_ack;
                pop      = id_valid && id_ready;
                accepted = ack_v && !m_dead && !redirect_valid;
                if (chk_en) begin
                    check("valid_vs_model", 32'(id_valid), 32'(m_cnt != 0));
                    if (m_cnt >= DEPTH) check("req_when_full", 32'(imem_req), 32'd0);
                    if (id_valid) begin
                        check("id_pc_stream", id_pc, m_next);
                        check("id_instr_data", id_instr, memf(id_pc));
                        check("id_adel_clear", 32'(id_adel), 32'd0);
                    end
                    if (accepted) check("fetch_addr", imem_addr, m_fetch);
                    if (prev_hold) begin
                        check("req_held", 32'(imem_req), 32'd1);
                        check("addr_held", imem_addr, prev_addr);
                    end
                end
                prev_hold = imem_req && !imem_ack;
                prev_addr = imem_addr;
                if (pop) begin m_next = m_next + 32'd4; m_cnt--; end
                if (accepted) begin m_fetch = m_fetch + 32'd4; m_cnt++; end
                if (ack_v) m_dead = 1'b0;
                if (redirect_valid) begin
                    m_cnt = 0;
                    m_fetch = tgt_of(redirect_pc);
                    m_next = tgt_of(redirect_pc);
                    if (imem_req && !imem_ack) m_dead = 1'b1;
                end
            end
        end
    end

    initial begin
        bit ok;
        int acks;
        logic [31:0] seq [3];
        n_chk = 0; n_fail = 0;
        reset = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        mem_auto = 1'b0; mem_rand = 1'b0; man_ack = 1'b0; man_rdata = '0; chk_en = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RST_PC);
        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instr", id_instr, 32'd0);
        check("rst_id_pc", id_pc, 32'd0);
        check("rst_id_adel", 32'(id_adel), 32'd0);

        // Zero-wait memory, decode always ready: back-to-back fetch
        step();
        reset = 1'b0; mem_auto = 1'b1; id_ready = 1'b1; chk_en = 1'b1;
        @(negedge clk);
        check("first_cycle_no_req", 32'(imem_req), 32'd0);
        seq[0] = 32'hBFC0_0000; seq[1] = 32'hBFC0_0004; seq[2] = 32'hBFC0_0008;
        @(negedge clk);
        check("stream_req0", imem_addr, seq[0]);
        check("stream_valid0", 32'(id_valid), 32'd0);
        for (int k = 1; k < 3; k++) begin
            @(negedge clk);
            check("stream_req", imem_addr, seq[k]);
            check("stream_req_on", 32'(imem_req), 32'd1);
            check("stream_id_pc", id_pc, seq[k-1]);
        end

        // Decode stalled: buffer fills after exactly DEPTH acks
        step();
        id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hBFC0_0000;
        step();
        redirect_valid = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (imem_req && imem_ack) acks++;
        end
        check("stall_acks", 32'(acks), 32'd2);
        check("stall_req_off", 32'(imem_req), 32'd0);
        check("stall_head_pc", id_pc, 32'hBFC0_0000);
        step();
        id_ready = 1'b1;
        wait_req(5, ok);
        if (ok) check("resume_addr", imem_addr, 32'hBFC0_0008);

        // Reset mid-request, late ack ignored
        step();
        mem_auto = 1'b0; man_ack = 1'b0;
        wait_req(8, ok);
        step();
        reset = 1'b1;
        #1;
        check("async_req_drop", 32'(imem_req), 32'd0);
        step();
        reset = 1'b0; man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("post_rst_idle", 32'(imem_req), 32'd0);
        step();
        man_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", 32'(id_valid), 32'd0);
        check("post_rst_req", imem_addr, 32'hBFC0_0000);

        // Redirect while request outstanding, ack 3 cycles after req
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
        @(negedge clk);
        check("discard_addr0", imem_addr, 32'hBFC0_0000);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("discard_req", 32'(imem_req), 32'd1);
        check("discard_addr1", imem_addr, 32'hBFC0_0000);
        step();
        man_ack = 1'b1; man_rdata = 32'h1111_2222;
        @(negedge clk);
        check("discard_addr2", imem_addr, 32'hBFC0_0000);
        step();
        man_ack = 1'b0;
        @(negedge clk);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h8000_1000);
        step();
        mem_auto = 1'b1;
        wait_valid(6, ok);
        if (ok) check("redir_first_pc", id_pc, 32'h8000_1000);

        // Redirect coinciding with ack and pop
        repeat (3) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
        @(negedge clk);
        check("coinc_pop_valid", 32'(id_valid), 32'd1);
        check("coinc_ack", 32'(imem_ack && imem_req), 32'd1);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("coinc_flushed", 32'(id_valid), 32'd0);
        wait_valid(6, ok);
        if (ok) check("coinc_target_pc", id_pc, 32'h0040_0000);

        // PC wraps modulo 2^32
        step();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        seq[0] = 32'hFFFF_FFF8; seq[1] = 32'hFFFF_FFFC; seq[2] = 32'h0000_0000;
        for (int k = 0; k < 3; k++) begin
            wait_valid(6, ok);
            if (ok) check("wrap_pc", id_pc, seq[k]);
        end

`ifdef IFETCH_ADEL_CHECK_EN
        // Misaligned redirect traps with an address-error entry
        step();
        chk_en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
        step();
        redirect_valid = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (imem_req) acks++;
        end
        check("adel_no_req", 32'(acks), 32'd0);
        check("adel_valid", 32'(id_valid), 32'd1);
        check("adel_flag", 32'(id_adel), 32'd1);
        check("adel_instr", id_instr, 32'd0);
        check("adel_pc", id_pc, 32'h8000_1002);
        step();
        id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
        step();
        redirect_valid = 1'b0; chk_en = 1'b1;
        wait_valid(6, ok);
        if (ok) check("adel_resume_pc", id_pc, 32'h8000_2000);
`else
        // Low target bits are ignored
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_1002;
        step();
        redirect_valid = 1'b0;
        wait_valid(6, ok);
        if (ok) check("align_pc", id_pc, 32'h8000_1000);
`endif

        // Randomized traffic
        step();
        mem_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            step();
            id_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 499) == 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            r = $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
`ifdef IFETCH_ADEL_CHECK_EN
            r = r & 32'hFFFF_FFFC;
`endif
            redirect_pc = r;
        end
        step();
        reset = 1'b0; redirect_valid = 1'b0;
        repeat (4) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
